// File: rtl/axicb_mst_switch_rd_ostdg_pkg.sv
// Shared types and helpers for the AXI crossbar master-side read switch.
// Holds the outstanding-counter width and the R-ID mask matcher.
package axicb_pkg;

    localparam int OSTDG_W    = 8;
    localparam int MASK_VEC_W = 256;

    typedef logic [OSTDG_W-1:0] ostdg_t;

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } arb_state_e;

    // Extracts mask slot idx from a packed mask vector and tests it against an ID.
    function automatic logic id_match(input logic [MASK_VEC_W-1:0] masks,
                                      input int unsigned           idx,
                                      input int unsigned           id_w,
                                      input logic [31:0]           id);
        logic [31:0] keep;
        logic [31:0] mask;
        keep = (id_w >= 32) ? '1 : ((32'd1 << id_w) - 32'd1);
        mask = 32'(masks >> (idx * id_w)) & keep;
        return (mask & id & keep) == mask;
    endfunction

endpackage

// File: rtl/axicb_mst_switch_rd_ostdg_if.sv
// AR/R signal bundle between the upstream masters, the switch and the slave.
// The switch uses the slave modport; the master modport is the environment view.
interface axicb_mst_switch_rd_ostdg_if #(
    parameter int MST_NB = 4,
    parameter int ARCH_W = 8,
    parameter int RCH_W  = 8
);
    logic [MST_NB-1:0]        i_arvalid;
    logic [MST_NB-1:0]        i_arready;
    logic [MST_NB*ARCH_W-1:0] i_arch;
    logic [MST_NB-1:0]        i_rvalid;
    logic [MST_NB-1:0]        i_rlast;
    logic [MST_NB-1:0]        i_rready;
    logic [RCH_W-1:0]         i_rch;
    logic                     o_arvalid;
    logic                     o_arready;
    logic [ARCH_W-1:0]        o_arch;
    logic                     o_rvalid;
    logic                     o_rready;
    logic                     o_rlast;
    logic [RCH_W-1:0]         o_rch;

    modport slave (
        input  i_arvalid, i_arch, i_rready, o_arready, o_rvalid, o_rlast, o_rch,
        output i_arready, i_rvalid, i_rlast, i_rch, o_arvalid, o_arch, o_rready
    );

    modport master (
        output i_arvalid, i_arch, i_rready, o_arready, o_rvalid, o_rlast, o_rch,
        input  i_arready, i_rvalid, i_rlast, i_rch, o_arvalid, o_arch, o_rready
    );

endinterface

// File: rtl/axicb_mst_switch_rd_ostdg_rr_arb.sv
// Round-robin arbiter with one-hot grant; lock freezes the current grant
// while the downstream AR is stalled, and the pointer advances on acceptance.
module axicb_rr_arb
    import axicb_pkg::*;
#(
    parameter int REQ_NB = 4
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic [REQ_NB-1:0] req,
    input  logic              lock,
    output logic [REQ_NB-1:0] grant
);

    localparam int PTR_W = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;

    arb_state_e        state_q, state_d;
    logic [REQ_NB-1:0] hold_q, hold_d;
    logic [REQ_NB-1:0] pick;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin : rr_pick
        int idx;
        pick = '0;
        idx  = 0;
        for (int k = 0; k < REQ_NB; k++) begin
            idx = (int'(ptr_q) + k) % REQ_NB;
            if (pick == '0 && req[idx]) pick[idx] = 1'b1;
        end
    end

    // lock is asserted only while a grant is presented but not accepted.
    always_comb begin
        state_d = lock ? ARB_LOCKED : ARB_OPEN;
        grant   = (state_q == ARB_LOCKED) ? hold_q : pick;
        hold_d  = grant;
        ptr_d   = ptr_q;
        if (|grant && !lock) begin
            for (int k = 0; k < REQ_NB; k++) begin
                if (grant[k]) ptr_d = PTR_W'((k + 1) % REQ_NB);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= ARB_OPEN;
            hold_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: rtl/axicb_mst_switch_rd_ostdg.sv
// Master-side read switch: arbitrates AR from MST_NB masters onto one slave,
// routes R beats back by ID mask, and tracks outstanding reads and R timeouts.
module axicb_mst_switch_rd_ostdg
    import axicb_pkg::*;
#(
    parameter int                         AXI_ID_W       = 8,
    parameter int                         MST_NB         = 4,
    parameter int                         ARCH_W         = 8,
    parameter int                         RCH_W          = 8,
    parameter logic [MST_NB*AXI_ID_W-1:0] MST_ID_MASK    = {8'h30, 8'h20, 8'h10, 8'h00},
    parameter int                         OSTDG_MAX      = 4,
    parameter int                         TIMEOUT_CYCLES = 1024
) (
    input  logic                        aclk,
    input  logic                        srst,
    axicb_mst_switch_rd_ostdg_if.slave  bus,
    output logic [MST_NB*OSTDG_W-1:0]   ostdg_cnt,
    output logic                        rd_err,
    output logic [MST_NB-1:0]           timeout
);

    localparam int               TMR_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(TIMEOUT_CYCLES);
    localparam ostdg_t           CNT_MAX = OSTDG_W'(OSTDG_MAX);

    logic [MST_NB-1:0] eligible;
    logic [MST_NB-1:0] grant;
    logic [MST_NB-1:0] ar_hs;
    logic [MST_NB-1:0] id_hit;
    logic [MST_NB-1:0] route_oh;
    logic [MST_NB-1:0] err_vec;
    logic [ARCH_W-1:0] arch_mux;
    logic              arb_lock;
    logic              route_hit;
    logic              r_hs;
    logic              rd_err_q, rd_err_d;

    axicb_rr_arb #(
        .REQ_NB (MST_NB)
    ) u_arb (
        .aclk  (aclk),
        .srst  (srst),
        .req   (eligible),
        .lock  (arb_lock),
        .grant (grant)
    );

    always_comb begin
        arch_mux = '0;
        for (int m = 0; m < MST_NB; m++) begin
            if (grant[m]) arch_mux |= bus.i_arch[m*ARCH_W +: ARCH_W];
        end
    end

    assign bus.o_arvalid = ~srst & (|grant);
    assign bus.o_arch    = arch_mux;
    assign arb_lock      = bus.o_arvalid & ~bus.o_arready;
    assign bus.i_arready = srst ? '0 : (grant & {MST_NB{bus.o_arready}});
    assign ar_hs         = bus.i_arready & bus.i_arvalid;

    // Lowest matching mask wins: isolate the least significant hit bit.
    assign route_oh  = id_hit & ~(id_hit - 1'b1);
    assign route_hit = |id_hit;

    assign bus.i_rch    = bus.o_rch;
    assign bus.i_rvalid = srst ? '0 : (route_oh & {MST_NB{bus.o_rvalid}});
    assign bus.i_rlast  = route_oh & {MST_NB{bus.o_rlast}};
    assign bus.o_rready = ~srst & (route_hit ? |(bus.i_rready & route_oh) : 1'b1);
    assign r_hs         = bus.o_rvalid & bus.o_rready;

    assign rd_err_d = (r_hs & ~route_hit) | (|err_vec);
    assign rd_err   = rd_err_q;

    always_ff @(posedge aclk) begin
        if (srst) rd_err_q <= 1'b0;
        else      rd_err_q <= rd_err_d;
    end

    for (genvar m = 0; m < MST_NB; m++) begin : g_mst
        ostdg_t           cnt_q, cnt_d;
        logic [TMR_W-1:0] tmr_q, tmr_d;
        logic             to_q;
        logic             r_beat, inc, dec;

        assign id_hit[m]   = id_match(MASK_VEC_W'(MST_ID_MASK), m, AXI_ID_W,
                                      32'(bus.o_rch[AXI_ID_W-1:0]));
        assign r_beat      = r_hs & route_oh[m];
        assign inc         = ar_hs[m];
        assign dec         = r_beat & bus.o_rlast;
        assign err_vec[m]  = dec & (cnt_q == '0);
        assign eligible[m] = bus.i_arvalid[m] & (cnt_q < CNT_MAX);

        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec)                      cnt_d = cnt_q + 1'b1;
            else if (dec && !inc && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
        end

        // Silence timer only runs while reads are pending and no beat comes back.
        always_comb begin
            tmr_d = tmr_q;
            if (cnt_q == '0 || r_beat) tmr_d = '0;
            else if (tmr_q != TMR_LIM)  tmr_d = tmr_q + 1'b1;
        end

        always_ff @(posedge aclk) begin
            if (srst) begin
                cnt_q <= '0;
                tmr_q <= '0;
                to_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                tmr_q <= tmr_d;
                to_q  <= to_q | ((TIMEOUT_CYCLES != 0) && (tmr_d == TMR_LIM));
            end
        end

        assign ostdg_cnt[m*OSTDG_W +: OSTDG_W] = cnt_q;
        assign timeout[m]                      = to_q;
    end

endmodule

// File: tb/tb_axicb_mst_switch_rd_ostdg.sv
// Directed bench for the read switch: arbitration order, grant lock, outstanding
// limits, R routing, unroutable beats and the silence timeout.
module tb_axicb_mst_switch_rd_ostdg;

    // Masks: M0=80, M1=10, M2=20, M3=08, so ID 40 matches no master.
    localparam logic [31:0] MASKS = {8'h08, 8'h20, 8'h10, 8'h80};
    localparam logic [31:0] ARCH  = 32'hA3A2A1A0;

    logic        clk;
    logic        srst;
    logic [31:0] ostdg_cnt;
    logic        rd_err;
    logic [3:0]  timeout;
    int          total;
    int          bad;

    axicb_mst_switch_rd_ostdg_if #(.MST_NB(4), .ARCH_W(8), .RCH_W(8)) bus ();

    axicb_mst_switch_rd_ostdg #(
        .AXI_ID_W       (8),
        .MST_NB         (4),
        .ARCH_W         (8),
        .RCH_W          (8),
        .MST_ID_MASK    (MASKS),
        .OSTDG_MAX      (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk      (clk),
        .srst      (srst),
        .bus       (bus),
        .ostdg_cnt (ostdg_cnt),
        .rd_err    (rd_err),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_arvalid = '0;
        bus.i_arch    = ARCH;
        bus.i_rready  = '0;
        bus.o_arready = 1'b0;
        bus.o_rvalid  = 1'b0;
        bus.o_rlast   = 1'b0;
        bus.o_rch     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        srst = 1'b1;
        cyc();
        cyc();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        srst          = 1'b1;
        bus.i_arvalid = '1;
        bus.o_arready = 1'b1;
        bus.o_rvalid  = 1'b1;
        bus.o_rch     = 8'h10;
        bus.i_rready  = '1;
        cyc();
        total++; if (bus.o_arvalid !== 1'b0) begin bad++; $display("FAIL rst_o_arvalid got=%0h exp=0", bus.o_arvalid); end
        total++; if (bus.i_arready !== 4'h0) begin bad++; $display("FAIL rst_i_arready got=%0h exp=0", bus.i_arready); end
        total++; if (bus.i_rvalid !== 4'h0) begin bad++; $display("FAIL rst_i_rvalid got=%0h exp=0", bus.i_rvalid); end
        total++; if (bus.o_rready !== 1'b0) begin bad++; $display("FAIL rst_o_rready got=%0h exp=0", bus.o_rready); end
        total++; if (ostdg_cnt !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%0h exp=0", ostdg_cnt); end
        total++; if (rd_err !== 1'b0) begin bad++; $display("FAIL rst_rd_err got=%0h exp=0", rd_err); end
        total++; if (timeout !== 4'h0) begin bad++; $display("FAIL rst_timeout got=%0h exp=0", timeout); end
        idle_inputs();
        srst = 1'b0;
        cyc();
        total++; if (ostdg_cnt !== 32'h0) begin bad++; $display("FAIL rst_cnt_after got=%0h exp=0", ostdg_cnt); end
    endtask

    task automatic test_round_robin();
        int exp_g[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        bus.i_arvalid = '1;
        bus.o_arready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (bus.i_arready !== 4'(1 << exp_g[i])) begin bad++; $display("FAIL rr_grant[%0d] got=%0h exp=%0h", i, bus.i_arready, 4'(1 << exp_g[i])); end
            total++; if (bus.o_arch !== 8'(8'hA0 + exp_g[i])) begin bad++; $display("FAIL rr_arch[%0d] got=%0h exp=%0h", i, bus.o_arch, 8'(8'hA0 + exp_g[i])); end
            cyc();
        end
        idle_inputs();
        total++; if (ostdg_cnt !== 32'h01010202) begin bad++; $display("FAIL rr_cnt got=%0h exp=01010202", ostdg_cnt); end
    endtask

    task automatic test_lock();
        do_reset();
        bus.o_arready = 1'b1;
        bus.i_arvalid = 4'b0010;
        #1;
        total++; if (bus.i_arready !== 4'b0010) begin bad++; $display("FAIL lock_first got=%0h exp=2", bus.i_arready); end
        cyc();
        bus.o_arready = 1'b0;
        #1;
        total++; if (bus.o_arch !== 8'hA1) begin bad++; $display("FAIL lock_arch0 got=%0h exp=a1", bus.o_arch); end
        cyc();
        bus.i_arvalid = 4'b0110;
        for (int i = 1; i < 5; i++) begin
            #1;
            total++; if (bus.o_arch !== 8'hA1) begin bad++; $display("FAIL lock_arch%0d got=%0h exp=a1", i, bus.o_arch); end
            total++; if (bus.i_arready !== 4'h0) begin bad++; $display("FAIL lock_ready%0d got=%0h exp=0", i, bus.i_arready); end
            cyc();
        end
        bus.o_arready = 1'b1;
        #1;
        total++; if (bus.i_arready !== 4'b0010) begin bad++; $display("FAIL lock_release got=%0h exp=2", bus.i_arready); end
        cyc();
        bus.i_arvalid = 4'b0100;
        #1;
        total++; if (bus.i_arready !== 4'b0100 || bus.o_arch !== 8'hA2) begin bad++; $display("FAIL lock_next got=%0h/%0h exp=4/a2", bus.i_arready, bus.o_arch); end
        cyc();
        idle_inputs();
        total++; if (ostdg_cnt !== 32'h00010200) begin bad++; $display("FAIL lock_cnt got=%0h exp=00010200", ostdg_cnt); end
    endtask

    task automatic test_ostdg_limit();
        do_reset();
        bus.o_arready = 1'b1;
        bus.i_arvalid = 4'b0001;
        cyc();
        cyc();
        total++; if (bus.o_arvalid !== 1'b0 || bus.i_arready !== 4'h0) begin bad++; $display("FAIL ost_block got=%0h/%0h exp=0/0", bus.o_arvalid, bus.i_arready); end
        total++; if (ostdg_cnt[7:0] !== 8'd2) begin bad++; $display("FAIL ost_cnt2 got=%0d exp=2", ostdg_cnt[7:0]); end
        bus.o_rvalid = 1'b1;
        bus.o_rlast  = 1'b1;
        bus.o_rch    = 8'h80;
        #1;
        total++; if (bus.o_rready !== 1'b0 || bus.i_rvalid !== 4'b0001) begin bad++; $display("FAIL ost_bp got=%0h/%0h exp=0/1", bus.o_rready, bus.i_rvalid); end
        cyc();
        total++; if (ostdg_cnt[7:0] !== 8'd2) begin bad++; $display("FAIL ost_bp_cnt got=%0d exp=2", ostdg_cnt[7:0]); end
        bus.i_rready = 4'b0001;
        #1;
        total++; if (bus.o_rready !== 1'b1 || bus.i_rlast !== 4'b0001) begin bad++; $display("FAIL ost_rlast got=%0h/%0h exp=1/1", bus.o_rready, bus.i_rlast); end
        cyc();
        bus.o_rvalid = 1'b0;
        bus.o_rlast  = 1'b0;
        bus.i_rready = '0;
        #1;
        total++; if (ostdg_cnt[7:0] !== 8'd1) begin bad++; $display("FAIL ost_cnt1 got=%0d exp=1", ostdg_cnt[7:0]); end
        total++; if (bus.i_arready !== 4'b0001) begin bad++; $display("FAIL ost_reopen got=%0h exp=1", bus.i_arready); end
        cyc();
        idle_inputs();
        total++; if (ostdg_cnt[7:0] !== 8'd2) begin bad++; $display("FAIL ost_cnt_again got=%0d exp=2", ostdg_cnt[7:0]); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus.o_arready = 1'b1;
        bus.i_arvalid = 4'b1000;
        cyc();
        total++; if (ostdg_cnt !== 32'h01000000) begin bad++; $display("FAIL same_pre got=%0h exp=01000000", ostdg_cnt); end
        bus.o_rvalid = 1'b1;
        bus.o_rlast  = 1'b1;
        bus.o_rch    = 8'h08;
        bus.i_rready = 4'b1000;
        #1;
        total++; if (bus.i_arready !== 4'b1000 || bus.i_rvalid !== 4'b1000) begin bad++; $display("FAIL same_hs got=%0h/%0h exp=8/8", bus.i_arready, bus.i_rvalid); end
        cyc();
        total++; if (ostdg_cnt !== 32'h01000000 || rd_err !== 1'b0) begin bad++; $display("FAIL same_cnt got=%0h/%0h exp=01000000/0", ostdg_cnt, rd_err); end
        bus.i_arvalid = '0;
        cyc();
        idle_inputs();
        total++; if (ostdg_cnt !== 32'h0) begin bad++; $display("FAIL same_drain got=%0h exp=0", ostdg_cnt); end
    endtask

    task automatic test_unroutable();
        do_reset();
        bus.o_rvalid = 1'b1;
        bus.o_rlast  = 1'b1;
        bus.o_rch    = 8'h40;
        #1;
        total++; if (bus.o_rready !== 1'b1 || bus.i_rvalid !== 4'h0) begin bad++; $display("FAIL unr_drain got=%0h/%0h exp=1/0", bus.o_rready, bus.i_rvalid); end
        cyc();
        idle_inputs();
        total++; if (rd_err !== 1'b1) begin bad++; $display("FAIL unr_pulse got=%0h exp=1", rd_err); end
        cyc();
        total++; if (rd_err !== 1'b0 || ostdg_cnt !== 32'h0) begin bad++; $display("FAIL unr_end got=%0h/%0h exp=0/0", rd_err, ostdg_cnt); end
        bus.o_rvalid = 1'b1;
        bus.o_rlast  = 1'b1;
        bus.o_rch    = 8'h20;
        bus.i_rready = 4'b0100;
        cyc();
        idle_inputs();
        total++; if (rd_err !== 1'b1 || ostdg_cnt !== 32'h0) begin bad++; $display("FAIL idle_last got=%0h/%0h exp=1/0", rd_err, ostdg_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.o_arready = 1'b1;
        bus.i_arvalid = 4'b0100;
        cyc();
        idle_inputs();
        total++; if (ostdg_cnt !== 32'h00010000) begin bad++; $display("FAIL to_cnt got=%0h exp=00010000", ostdg_cnt); end
        repeat (15) cyc();
        total++; if (timeout !== 4'h0) begin bad++; $display("FAIL to_early got=%0h exp=0", timeout); end
        cyc();
        total++; if (timeout !== 4'b0100) begin bad++; $display("FAIL to_set got=%0h exp=4", timeout); end
        bus.o_rvalid = 1'b1;
        bus.o_rlast  = 1'b1;
        bus.o_rch    = 8'h20;
        bus.i_rready = 4'b0100;
        cyc();
        idle_inputs();
        total++; if (timeout !== 4'b0100 || ostdg_cnt !== 32'h0 || rd_err !== 1'b0) begin bad++; $display("FAIL to_sticky got=%0h/%0h/%0h exp=4/0/0", timeout, ostdg_cnt, rd_err); end
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        total++; if (timeout !== 4'h0) begin bad++; $display("FAIL to_clear got=%0h exp=0", timeout); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        srst  = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_lock();
        test_ostdg_limit();
        test_same_cycle();
        test_unroutable();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axicb_mst_switch_rd_ostdg.md
AXICB_MST_SWITCH_RD_OSTDG -- requirements
Module: axicb_mst_switch_rd_ostdg

Interface
REQ-001 Parameters SHALL be (name, default, meaning): AXI_ID_W, 8, ID width; MST_NB, 4, masters 1..8; ARCH_W, 8, AR payload width, ID in bits [AXI_ID_W-1:0]; RCH_W, 8, R payload width, ID in bits [AXI_ID_W-1:0]; MST_ID_MASK, {8'h30,8'h20,8'h10,8'h00}, packed MST_NB*AXI_ID_W, one mask per master; OSTDG_MAX, 4, max outstanding reads per master (1..255); TIMEOUT_CYCLES, 1024, R-silence limit, 0 disables.
REQ-002 aclk  in  1  clock, all logic on rising edge.
REQ-003 srst  in  1  reset, synchronous, active-high.
REQ-004 i_arvalid/i_arready  in/out  MST_NB  per-master AR handshake; i_arch  in  MST_NB*ARCH_W  AR payloads.
REQ-005 i_rvalid, i_rlast  out  MST_NB  per-master R qualifiers; i_rready  in  MST_NB; i_rch  out  RCH_W  shared R payload.
REQ-006 o_arvalid out 1, o_arready in 1, o_arch out ARCH_W  slave AR; o_rvalid in 1, o_rready out 1, o_rlast in 1, o_rch in RCH_W  slave R.
REQ-007 ostdg_cnt  out  MST_NB*8  per-master outstanding count; rd_err  out  1  one-cycle pulse on unroutable R beat; timeout  out  MST_NB  sticky per-master timeout flags.

Function
REQ-008 Master m SHALL be eligible iff i_arvalid[m]=1 and ostdg_cnt[m]<OSTDG_MAX.
REQ-009 Arbitration SHALL be round-robin over eligible masters, searching upward from pointer, wrapping MST_NB-1 to 0; pointer SHALL become granted index+1 (mod MST_NB) on AR handshake.
REQ-010 When unlocked and any master eligible, grant SHALL be chosen combinationally in the same cycle; o_arvalid=1, o_arch=i_arch of granted master, zero-latency path.
REQ-011 If o_arvalid=1 and o_arready=0, grant SHALL lock (registered) until handshake; o_arch SHALL stay stable while locked.
REQ-012 i_arready[m] SHALL equal grant[m] & o_arready; all other bits 0.
REQ-013 ostdg_cnt[m] SHALL +1 on AR handshake of m, -1 on R handshake with o_rlast=1 routed to m, unchanged when both occur in the same cycle.
REQ-014 R routing: master m targeted iff (MST_ID_MASK[m] & o_rch ID)==MST_ID_MASK[m]; lowest matching index wins.
REQ-015 i_rvalid[m]=o_rvalid, i_rlast[m]=o_rlast for the routed master only, 0 elsewhere; o_rready=i_rready[routed]; i_rch=o_rch unconditionally.
REQ-016 No mask match: o_rready SHALL be 1 (beat drained), rd_err SHALL pulse for each such accepted beat, counters unchanged.
REQ-017 Decrement from 0 (R last to idle master) SHALL saturate at 0 and pulse rd_err.
REQ-018 Per master, a timer SHALL count cycles while ostdg_cnt>0 and no R beat to that master; reset on any routed R handshake or cnt=0; reaching TIMEOUT_CYCLES SHALL set timeout[m] until srst. Timer SHALL saturate.
REQ-019 A master with timeout[m]=1 SHALL remain arbitrable; flag is status only.

Reset
REQ-020 srst=1 SHALL clear within one edge: pointer=0, lock=0, all ostdg_cnt=0, timers=0, timeout=0, rd_err=0.
REQ-021 During srst, o_arvalid, i_arready, i_rvalid, o_rready SHALL be 0; reset mid-burst abandons state without recovery.

Structure
REQ-022 OSTDG counter width (8) and mask-extraction function SHALL live in shared package axicb_pkg.
REQ-023 Arbitration SHALL be sub-module axicb_rr_arb (parameter REQ_NB; ports aclk, srst, req, lock, grant) with one-hot grant.
REQ-024 Counters and timers SHALL be generate-loop instances per master, no fixed-4 unrolled code.

Verification
REQ-025 MST_NB=4, all masters assert arvalid, o_arready=1 continuously -> grants 0,1,2,3,0 on consecutive cycles.
REQ-026 M1 AR with o_arready low 5 cycles while M2 requests -> o_arch frozen to M1 payload, i_arready[2]=0, M1 granted on cycle 6.
REQ-027 OSTDG_MAX=2, M0 issues 2 ARs, no R -> third AR blocked, ostdg_cnt[0]=2; R with rlast, ID 8'h00 -> cnt=1, next AR accepted.
REQ-028 Same-cycle AR handshake and R last for M3 -> ostdg_cnt[3] unchanged.
REQ-029 R beat with ID 8'h40 under masks 00/10/20/30 matching none apart from M0 disabled by mask 8'h80 config -> o_rready=1, rd_err pulses 1 cycle.
REQ-030 TIMEOUT_CYCLES=16, M2 one outstanding, no R 16 cycles -> timeout[2]=1, stays after R arrives, clears on srst.
